// File: rtl/int_sop_n_dspchain_acc_pkg.sv
// Shared constants and helpers for the cascadable integer sum-of-products slice.
// Mode bit positions and the range-limit clamp used when forming the result.
package int_sop_pkg;

  localparam int MODE_W      = 3;
  localparam int MODE_ACC    = 0;
  localparam int MODE_CHAIN  = 1;
  localparam int MODE_SIGNED = 2;

  // Wide enough to hold any extended sum for chain widths up to 62 bits.
  localparam int CLAMP_W = 64;
  typedef logic [CLAMP_W-1:0] clamp_t;

  // Returns value unchanged when it lies inside the width-bit range, else the violated limit.
  function automatic clamp_t sop_clamp(input clamp_t value, input logic is_signed, input int width);
    logic signed [CLAMP_W-1:0] sv;
    logic signed [CLAMP_W-1:0] s_hi;
    logic signed [CLAMP_W-1:0] s_lo;
    clamp_t                    u_hi;
    clamp_t                    res;
    sv   = value;
    s_hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    s_lo = -s_hi - 64'sd1;
    u_hi = (64'd1 << width) - 64'd1;
    res  = value;
    if (is_signed) begin
      if (sv > s_hi) res = s_hi;
      else if (sv < s_lo) res = s_lo;
    end else if (value > u_hi) begin
      res = u_hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/int_sop_n_dspchain_acc_if.sv
// Beat-level bus of the sum-of-products slice: operands and cascade in, result out.
// in_valid qualifies one beat per cycle and there is no ready: the slice always accepts.
interface int_sop_n_dspchain_acc_if #(
  parameter int NUM_TERMS   = 2,
  parameter int X_WIDTH     = 18,
  parameter int Y_WIDTH     = 19,
  parameter int CHAIN_WIDTH = 37
);
  import int_sop_pkg::*;

  logic                           in_valid;
  logic [MODE_W-1:0]              mode_sigs;
  logic                           acc_clear;
  logic [NUM_TERMS*X_WIDTH-1:0]   x_flat;
  logic [NUM_TERMS*Y_WIDTH-1:0]   y_flat;
  logic [CHAIN_WIDTH-1:0]         chainin;
  logic [CHAIN_WIDTH-1:0]         resulta;
  logic [CHAIN_WIDTH-1:0]         chainout;
  logic                           out_valid;
  logic                           overflow;

  modport master (
    output in_valid, mode_sigs, acc_clear, x_flat, y_flat, chainin,
    input  resulta, chainout, out_valid, overflow
  );

  modport slave (
    input  in_valid, mode_sigs, acc_clear, x_flat, y_flat, chainin,
    output resulta, chainout, out_valid, overflow
  );

endinterface

// File: rtl/int_sop_n_dspchain_acc_adder_tree.sv
// Combinational sum of NUM_TERMS equal-width products, each sign- or zero-extended
// to the sum width before being added.
module int_sop_adder_tree #(
  parameter int NUM_TERMS = 2,
  parameter int TERM_W    = 37,
  parameter int SUM_W     = 39
) (
  input  logic [NUM_TERMS*TERM_W-1:0] terms_i,
  input  logic                        is_signed_i,
  output logic [SUM_W-1:0]            sum_o
);

  logic [TERM_W-1:0] term;

  always_comb begin
    sum_o = '0;
    term  = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      term  = terms_i[i*TERM_W +: TERM_W];
      sum_o = sum_o + {{(SUM_W-TERM_W){is_signed_i & term[TERM_W-1]}}, term};
    end
  end

endmodule

// File: rtl/int_sop_n_dspchain_acc.sv
// N-term integer sum-of-products slice with cascade input, optional accumulation,
// range check with wrap or saturate, and a sticky overflow flag. Three register stages.
module int_sop_n_dspchain_acc
  import int_sop_pkg::*;
#(
  parameter int NUM_TERMS   = 2,
  parameter int X_WIDTH     = 18,
  parameter int Y_WIDTH     = 19,
  parameter int CHAIN_WIDTH = 37,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  int_sop_n_dspchain_acc_if.slave bus
);

  localparam int PW  = X_WIDTH + Y_WIDTH;
  localparam int SW  = CHAIN_WIDTH + 2;
  localparam int EXT = SW - CHAIN_WIDTH;

  // Stage 1: captured beat
  logic [NUM_TERMS*X_WIDTH-1:0] x_q;
  logic [NUM_TERMS*Y_WIDTH-1:0] y_q;
  logic [CHAIN_WIDTH-1:0]       ch1_q;
  logic [MODE_W-1:0]            mode1_q;
  logic                         clr1_q;
  logic                         v1_q;

  // Stage 2: products and the side-band that travels with them
  logic [NUM_TERMS*PW-1:0]      prod_d;
  logic [NUM_TERMS*PW-1:0]      prod_q;
  logic [CHAIN_WIDTH-1:0]       ch2_q;
  logic [MODE_W-1:0]            mode2_q;
  logic                         clr2_q;
  logic                         v2_q;

  // Stage 3: result register and flag
  logic [CHAIN_WIDTH-1:0]       resulta_d;
  logic [CHAIN_WIDTH-1:0]       resulta_q;
  logic                         ovf_d;
  logic                         ovf_q;
  logic                         out_valid_q;

  // Extending both operands to the product width makes one multiplier serve
  // signed and unsigned modes: the low PW bits are exact either way.
  for (genvar gi = 0; gi < NUM_TERMS; gi++) begin : g_mul
    logic [X_WIDTH-1:0] xs;
    logic [Y_WIDTH-1:0] ys;
    logic [PW-1:0]      xe;
    logic [PW-1:0]      ye;
    assign xs = x_q[gi*X_WIDTH +: X_WIDTH];
    assign ys = y_q[gi*Y_WIDTH +: Y_WIDTH];
    assign xe = {{Y_WIDTH{mode1_q[MODE_SIGNED] & xs[X_WIDTH-1]}}, xs};
    assign ye = {{X_WIDTH{mode1_q[MODE_SIGNED] & ys[Y_WIDTH-1]}}, ys};
    assign prod_d[gi*PW +: PW] = xe * ye;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      ch1_q   <= '0;
      mode1_q <= '0;
      clr1_q  <= 1'b0;
      v1_q    <= 1'b0;
      prod_q  <= '0;
      ch2_q   <= '0;
      mode2_q <= '0;
      clr2_q  <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      x_q     <= bus.x_flat;
      y_q     <= bus.y_flat;
      ch1_q   <= bus.chainin;
      mode1_q <= bus.mode_sigs;
      clr1_q  <= bus.acc_clear;
      v1_q    <= bus.in_valid;
      prod_q  <= prod_d;
      ch2_q   <= ch1_q;
      mode2_q <= mode1_q;
      clr2_q  <= clr1_q;
      v2_q    <= v1_q;
    end
  end

  logic [SW-1:0] tree_sum;

  int_sop_adder_tree #(
    .NUM_TERMS (NUM_TERMS),
    .TERM_W    (PW),
    .SUM_W     (SW)
  ) u_tree (
    .terms_i     (prod_q),
    .is_signed_i (mode2_q[MODE_SIGNED]),
    .sum_o       (tree_sum)
  );

  logic          sgn;
  logic [SW-1:0] chain_ext;
  logic [SW-1:0] acc_ext;
  logic [SW-1:0] total;
  clamp_t        total_ext;
  clamp_t        clamped;
  logic          ovf_now;

  always_comb begin
    sgn       = mode2_q[MODE_SIGNED];
    chain_ext = '0;
    acc_ext   = '0;
    if (mode2_q[MODE_CHAIN]) chain_ext = {{EXT{sgn & ch2_q[CHAIN_WIDTH-1]}}, ch2_q};
    if (mode2_q[MODE_ACC] && !clr2_q) acc_ext = {{EXT{sgn & resulta_q[CHAIN_WIDTH-1]}}, resulta_q};
    total     = tree_sum + chain_ext + acc_ext;
    total_ext = {{(CLAMP_W-SW){sgn & total[SW-1]}}, total};
    clamped   = sop_clamp(total_ext, sgn, CHAIN_WIDTH);
    ovf_now   = (clamped != total_ext);
    resulta_d = resulta_q;
    ovf_d     = ovf_q;
    // Bubbles leave the accumulator and flag untouched.
    if (v2_q) begin
      resulta_d = SATURATE ? clamped[CHAIN_WIDTH-1:0] : total[CHAIN_WIDTH-1:0];
      ovf_d     = (ovf_q & ~clr2_q) | ovf_now;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resulta_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      resulta_q   <= resulta_d;
      ovf_q       <= ovf_d;
      out_valid_q <= v2_q;
    end
  end

  assign bus.resulta   = resulta_q;
  assign bus.chainout  = resulta_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = ovf_q;

endmodule
